apb_uart_rx_regs: RTL and testbench
===================================

# apb_uart_rx_regs

Parametrised APB register slave for the UART receiver, the successor to the single-byte `apb_slave`. It sits between the APB bus and the UART RX core and drains received bytes into an internal RX FIFO. It exposes configuration, status, sticky-error and interrupt registers, and drives a level interrupt to the host.

## Interface
- `FIFO_DEPTH`, 4: RX FIFO entries; power of two, minimum 2.
- `BP_WIDTH`, 14: bit-period width; range 9..16.
- `ADDR_WIDTH`, 3: APB address width; registers 0..7 are decoded.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `psel`, `penable`, `pwrite` in 1: APB control.
- `paddr` in ADDR_WIDTH: register index.
- `pwdata` in 8: write data.
- `prdata` out 8: read data.
- `pslverr` out 1: error response.
- `rx_data` in 8: byte from the UART.
- `data_ready` in 1: UART has a byte; held high until acknowledged.
- `framing_error`, `overrun_error` in 1: UART error flags, valid with `data_ready`.
- `data_read` out 1: one-cycle acknowledge to the UART.
- `data_size` out 4: configured character length.
- `bit_period` out BP_WIDTH: configured bit period in clocks.
- `irq` out 1: level interrupt.

## Operation
- Register map:
  - 0 STATUS RO: b0 FIFO non-empty, b1 FIFO full.
  - 1 ERROR W1C: b0 framing, b1 UART overrun, b2 FIFO overflow. All bits sticky; writing 1 clears a bit.
  - 2 BIT_CR0 RW: `bit_period[7:0]`.
  - 3 BIT_CR1 RW: `bit_period[BP_WIDTH-1:8]`. Unused bits read 0 and ignore writes.
  - 4 DATA_CR RW: b[3:0] `data_size`. Legal values are 5..8; an illegal value leaves the register unchanged and raises `pslverr`.
  - 5 FIFO_LVL RO: occupancy count, 0..FIFO_DEPTH.
  - 6 RX_DATA RO: FIFO head. A read pops the FIFO; a read when empty returns 0 and raises `pslverr`.
  - 7 IRQ_CR RW: b7 enable, b[6:0] threshold.
- Any write to STATUS, FIFO_LVL or RX_DATA, or any access to an index above 7 (when ADDR_WIDTH > 3): `pslverr`, with no state change.
- Capture: on a rising edge of `data_ready` (compared against its registered copy), the block:
  - pushes `rx_data` masked to its low `data_size` bits;
  - ORs `framing_error` and `overrun_error` into ERROR;
  - pulses `data_read` in the next cycle.
- FIFO full at capture: the byte is dropped, ERROR.b2 is set, and `data_read` still pulses.
- Capture and RX_DATA pop in the same cycle: both take effect, and the count is unchanged, including when the FIFO is full.
- W1C and a new error in the same cycle: the set wins.
- `irq` = (IRQ_CR.b7 & count ≥ threshold & threshold ≠ 0) | (ERROR ≠ 0).
- Reset values:
  - `bit_period` 10, `data_size` 8, threshold 1, enable 0;
  - ERROR 0, FIFO empty;
  - `data_read` 0, `irq` 0.
  - `prdata` and `pslverr` are 0 whenever the bus is not in the access phase.

## Timing
- No wait states. The access phase is `psel & penable`.
- `prdata` and `pslverr` are combinational in the access phase and valid for that cycle.
- Register writes, pops and W1C take effect at the rising edge that ends the access phase. New values are visible on outputs in the following cycle.
- Capture latency: `data_ready` rises in cycle t, so:
  - push and `data_read` occur in t+1;
  - FIFO_LVL and `irq` reflect the new byte from t+2.
- `irq` is registered, so it follows its source condition by one cycle.
- `rst` asserted mid-transfer: the transfer is abandoned; the FIFO and all registers return to reset values at the next edge.

## Structure
- Package `apb_uart_pkg`:
  - register index localparams;
  - reset constants (bit period 10, data size 8, threshold 1);
  - ERROR bit indices;
  - data-size legal bounds.
- Sub-module `rx_fifo`: synchronous FIFO with WIDTH and DEPTH parameters, push/pop ports, full/empty flags and a count output; defined simultaneous push/pop at full.
- Top level: APB decode, control registers, capture edge detect, and irq logic.

## Test plan
- Reset with all UART inputs high:
  - `bit_period`=10, `data_size`=8, `data_read`=0, `irq`=0;
  - a FIFO_LVL read returns 0.
- Bit period:
  - write CR0=0xE8, CR1=0x03 → `bit_period`=1000, and both registers read back unchanged;
  - write DATA_CR=4 → `pslverr`=1 and `data_size` stays 8.
- Capture and read:
  - deliver 0xA5 then 0x3C with `data_size`=7 → one `data_read` pulse each, FIFO_LVL=2;
  - reads return 0x25 then 0x3C;
  - a third read → `prdata`=0 and `pslverr`=1.
- Overflow:
  - deliver 5 bytes with DEPTH=4 → ERROR=0x04 and `irq`=1;
  - writing 0x04 to ERROR → `irq`=0 and FIFO_LVL stays 4.
- Threshold:
  - IRQ_CR=0x82, deliver 1 byte → `irq`=0;
  - a 2nd byte → `irq`=1 two cycles after `data_ready` rises;
  - one RX_DATA pop → `irq`=0.
- Simultaneous events and reset:
  - capture coinciding with an RX_DATA pop on a full FIFO → count stays 4 and no overflow;
  - `framing_error` captured together with W1C of b0 → b0 stays set;
  - `rst` during an access phase → all reset values restored.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared constants for the UART RX APB register slave: register map,
// reset values, ERROR bit positions and character-length bounds.
package apb_uart_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_ERROR    = 3'd1;
  localparam logic [2:0] REG_BIT_CR0  = 3'd2;
  localparam logic [2:0] REG_BIT_CR1  = 3'd3;
  localparam logic [2:0] REG_DATA_CR  = 3'd4;
  localparam logic [2:0] REG_FIFO_LVL = 3'd5;
  localparam logic [2:0] REG_RX_DATA  = 3'd6;
  localparam logic [2:0] REG_IRQ_CR   = 3'd7;

  localparam int         RST_BIT_PERIOD = 10;
  localparam logic [3:0] RST_DATA_SIZE  = 4'd8;
  localparam logic [6:0] RST_THRESHOLD  = 7'd1;

  localparam int ERR_FRAMING  = 0;
  localparam int ERR_OVERRUN  = 1;
  localparam int ERR_OVERFLOW = 2;

  localparam logic [3:0] DATA_SIZE_MIN = 4'd5;
  localparam logic [3:0] DATA_SIZE_MAX = 4'd8;

  function automatic logic size_legal(input logic [3:0] size);
    return (size >= DATA_SIZE_MIN) && (size <= DATA_SIZE_MAX);
  endfunction

  // size is always held in 5..8, so the shift never exceeds 3
  function automatic logic [7:0] mask_char(input logic [7:0] data, input logic [3:0] size);
    logic [7:0] mask;
    mask = 8'hFF >> (4'd8 - size);
    return data & mask;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO for received characters. Pop is ignored when empty; a push
// at full is accepted only when a pop happens in the same cycle.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/apb_uart_rx_regs.sv
// APB register slave for the UART receiver: configuration, sticky errors,
// RX FIFO draining and a registered level interrupt.
module apb_uart_rx_regs
  import apb_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BP_WIDTH   = 14,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [7:0]            pwdata,
  output logic [7:0]            prdata,
  output logic                  pslverr,
  input  logic [7:0]            rx_data,
  input  logic                  data_ready,
  input  logic                  framing_error,
  input  logic                  overrun_error,
  output logic                  data_read,
  output logic [3:0]            data_size,
  output logic [BP_WIDTH-1:0]   bit_period,
  output logic                  irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                access, wr, rd, in_range;
  logic [2:0]          idx;
  logic [2:0]          err_q, err_nxt, err_set, w1c;
  logic [BP_WIDTH-1:0] bp_nxt;
  logic [3:0]          ds_nxt;
  logic                irq_en_q, en_nxt;
  logic [6:0]          thr_q, thr_nxt;
  logic                irq_nxt;
  logic                dr_p0, vld_p1, fe_p1, oe_p1;
  logic [7:0]          data_p1;
  logic                push, pop, full, empty;
  logic [CW-1:0]       count, cnt_nxt;
  logic [7:0]          head;

  assign access = psel & penable;
  assign wr     = access & pwrite;
  assign rd     = access & ~pwrite;
  assign idx    = paddr[2:0];

  if (ADDR_WIDTH > 3) begin : g_wide_addr
    assign in_range = ~|paddr[ADDR_WIDTH-1:3];
  end else begin : g_narrow_addr
    assign in_range = 1'b1;
  end

  assign pop       = rd & in_range & (idx == REG_RX_DATA) & ~empty;
  assign push      = vld_p1 & (~full | pop);
  assign data_read = vld_p1;

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (access) begin
      if (!in_range) begin
        pslverr = 1'b1;
      end else if (pwrite) begin
        case (idx)
          REG_STATUS, REG_FIFO_LVL, REG_RX_DATA: pslverr = 1'b1;
          REG_DATA_CR: pslverr = ~size_legal(pwdata[3:0]);
          default: ;
        endcase
      end else begin
        case (idx)
          REG_STATUS:   prdata = {6'd0, full, ~empty};
          REG_ERROR:    prdata = {5'd0, err_q};
          REG_BIT_CR0:  prdata = bit_period[7:0];
          REG_BIT_CR1:  prdata = 8'(bit_period >> 8);
          REG_DATA_CR:  prdata = {4'd0, data_size};
          REG_FIFO_LVL: prdata = 8'(count);
          REG_RX_DATA: begin
            prdata  = empty ? 8'd0 : head;
            pslverr = empty;
          end
          default:      prdata = {irq_en_q, thr_q};
        endcase
      end
    end
  end

  always_comb begin
    bp_nxt  = bit_period;
    ds_nxt  = data_size;
    en_nxt  = irq_en_q;
    thr_nxt = thr_q;
    w1c     = '0;
    if (wr && in_range) begin
      case (idx)
        REG_ERROR:   w1c = pwdata[2:0];
        REG_BIT_CR0: bp_nxt[7:0] = pwdata;
        REG_BIT_CR1: bp_nxt[BP_WIDTH-1:8] = pwdata[BP_WIDTH-9:0];
        REG_DATA_CR: if (size_legal(pwdata[3:0])) ds_nxt = pwdata[3:0];
        REG_IRQ_CR:  {en_nxt, thr_nxt} = pwdata;
        default: ;
      endcase
    end
    err_set               = '0;
    err_set[ERR_FRAMING]  = vld_p1 & fe_p1;
    err_set[ERR_OVERRUN]  = vld_p1 & oe_p1;
    err_set[ERR_OVERFLOW] = vld_p1 & full & ~pop;
    // a new error in the same cycle as its W1C survives
    err_nxt = (err_q & ~w1c) | err_set;
    cnt_nxt = count + CW'(push) - CW'(pop);
    irq_nxt = (en_nxt && (32'(cnt_nxt) >= 32'(thr_nxt)) && (thr_nxt != '0)) || (err_nxt != '0);
  end

  // p0 -> p1: data_ready edge detect and byte/flag capture. The registered
  // copy follows data_ready through reset so a line held high is not seen as an edge.
  always_ff @(posedge clk) begin
    dr_p0   <= data_ready;
    data_p1 <= mask_char(rx_data, data_size);
    fe_p1   <= framing_error;
    oe_p1   <= overrun_error;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_period <= BP_WIDTH'(RST_BIT_PERIOD);
      data_size  <= RST_DATA_SIZE;
      irq_en_q   <= 1'b0;
      thr_q      <= RST_THRESHOLD;
      err_q      <= '0;
      vld_p1     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      bit_period <= bp_nxt;
      data_size  <= ds_nxt;
      irq_en_q   <= en_nxt;
      thr_q      <= thr_nxt;
      err_q      <= err_nxt;
      vld_p1     <= data_ready & ~dr_p0;
      irq        <= irq_nxt;
    end
  end

  rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (data_p1),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_apb_uart_rx_regs.sv
// Directed bench for apb_uart_rx_regs: reset, configuration, capture, overflow,
// threshold interrupt, same-cycle events and reset during an access.
module tb_apb_uart_rx_regs;

  logic        tb_clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0]  paddr = '0;
  logic [7:0]  pwdata = '0;
  logic [7:0]  prdata;
  logic        pslverr;
  logic [7:0]  rx_data = '0;
  logic        data_ready = 1'b0, framing_error = 1'b0, overrun_error = 1'b0;
  logic        data_read;
  logic [3:0]  data_size;
  logic [13:0] bit_period;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 tb_clk = ~tb_clk;

  apb_uart_rx_regs #(
    .FIFO_DEPTH (4),
    .BP_WIDTH   (14),
    .ADDR_WIDTH (3)
  ) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pslverr       (pslverr),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .data_read     (data_read),
    .data_size     (data_size),
    .bit_period    (bit_period),
    .irq           (irq)
  );

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d, output logic err);
    @(posedge tb_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge tb_clk); #1;
    penable = 1'b1;
    @(negedge tb_clk);
    err = pslverr;
    @(posedge tb_clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d, output logic err);
    @(posedge tb_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge tb_clk); #1;
    penable = 1'b1;
    @(negedge tb_clk);
    d = prdata; err = pslverr;
    @(posedge tb_clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // irq_tr[k] is irq sampled k cycles after data_ready rises
  task automatic deliver(input logic [7:0] b, input logic fe, input logic oe,
                         output int pulses, output logic [2:0] irq_tr);
    @(posedge tb_clk); #1;
    rx_data = b; framing_error = fe; overrun_error = oe; data_ready = 1'b1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge tb_clk);
      pulses += int'(data_read);
      irq_tr[k] = irq;
    end
    @(posedge tb_clk); #1;
    data_ready = 1'b0; framing_error = 1'b0; overrun_error = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic e;
    rx_data = 8'hFF; data_ready = 1'b1; framing_error = 1'b1; overrun_error = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    n_cmp++; if (bit_period !== 14'd10) begin n_bad++; $display("FAIL rst_bit_period: got %0d want 10", bit_period); end
    n_cmp++; if (data_size !== 4'd8) begin n_bad++; $display("FAIL rst_data_size: got %0d want 8", data_size); end
    n_cmp++; if (data_read !== 1'b0) begin n_bad++; $display("FAIL rst_data_read: got %b want 0", data_read); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    @(posedge tb_clk); #1;
    rst = 1'b0;
    apb_read(3'd5, d, e);
    n_cmp++; if (d !== 8'd0) begin n_bad++; $display("FAIL rst_fifo_lvl: got %0d want 0", d); end
    apb_read(3'd1, d, e);
    n_cmp++; if (d !== 8'd0) begin n_bad++; $display("FAIL rst_error: got %h want 00", d); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq_after: got %b want 0", irq); end
    @(posedge tb_clk); #1;
    data_ready = 1'b0; framing_error = 1'b0; overrun_error = 1'b0; rx_data = 8'h00;
    @(posedge tb_clk); #1;
  endtask

  task automatic test_bit_period();
    logic [7:0] d; logic e;
    apb_write(3'd2, 8'hE8, e);
    apb_write(3'd3, 8'h03, e);
    n_cmp++; if (bit_period !== 14'd1000) begin n_bad++; $display("FAIL bp_1000: got %0d want 1000", bit_period); end
    apb_read(3'd2, d, e);
    n_cmp++; if (d !== 8'hE8) begin n_bad++; $display("FAIL bp_cr0_rb: got %h want e8", d); end
    apb_read(3'd3, d, e);
    n_cmp++; if (d !== 8'h03) begin n_bad++; $display("FAIL bp_cr1_rb: got %h want 03", d); end
    apb_write(3'd3, 8'hFF, e);
    apb_read(3'd3, d, e);
    n_cmp++; if (d !== 8'h3F) begin n_bad++; $display("FAIL bp_cr1_unused: got %h want 3f", d); end
    n_cmp++; if (bit_period !== 14'h3FE8) begin n_bad++; $display("FAIL bp_max: got %h want 3fe8", bit_period); end
    apb_write(3'd4, 8'h04, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL ds_illegal_err: got %b want 1", e); end
    n_cmp++; if (data_size !== 4'd8) begin n_bad++; $display("FAIL ds_illegal_keep: got %0d want 8", data_size); end
    apb_write(3'd0, 8'h01, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL ro_status_err: got %b want 1", e); end
  endtask

  task automatic test_capture_read();
    logic [7:0] d; logic e; int p; logic [2:0] tr;
    apb_write(3'd4, 8'h07, e);
    n_cmp++; if (e !== 1'b0 || data_size !== 4'd7) begin n_bad++; $display("FAIL ds_7: got err=%b size=%0d want err=0 size=7", e, data_size); end
    deliver(8'hA5, 1'b0, 1'b0, p, tr);
    n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL cap1_pulses: got %0d want 1", p); end
    deliver(8'h3C, 1'b0, 1'b0, p, tr);
    n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL cap2_pulses: got %0d want 1", p); end
    // setup phase must not drive read data
    @(posedge tb_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd5;
    @(negedge tb_clk);
    n_cmp++; if (prdata !== 8'd0 || pslverr !== 1'b0) begin n_bad++; $display("FAIL setup_idle: got prdata=%h err=%b want 00/0", prdata, pslverr); end
    @(posedge tb_clk); #1;
    penable = 1'b1;
    @(negedge tb_clk);
    n_cmp++; if (prdata !== 8'd2) begin n_bad++; $display("FAIL lvl_2: got %0d want 2", prdata); end
    @(posedge tb_clk); #1;
    psel = 1'b0; penable = 1'b0;
    apb_read(3'd0, d, e);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL status_ne: got %h want 01", d); end
    apb_read(3'd6, d, e);
    n_cmp++; if (d !== 8'h25 || e !== 1'b0) begin n_bad++; $display("FAIL rx_first: got %h err=%b want 25 err=0", d, e); end
    apb_read(3'd6, d, e);
    n_cmp++; if (d !== 8'h3C) begin n_bad++; $display("FAIL rx_second: got %h want 3c", d); end
    apb_read(3'd6, d, e);
    n_cmp++; if (d !== 8'h00 || e !== 1'b1) begin n_bad++; $display("FAIL rx_empty: got %h err=%b want 00 err=1", d, e); end
    apb_write(3'd4, 8'h08, e);
  endtask

  task automatic test_overflow();
    logic [7:0] d; logic e; int p; logic [2:0] tr;
    for (int i = 0; i < 5; i++) deliver(8'h10 + 8'(i), 1'b0, 1'b0, p, tr);
    apb_read(3'd1, d, e);
    n_cmp++; if (d !== 8'h04) begin n_bad++; $display("FAIL ovf_error: got %h want 04", d); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL ovf_irq: got %b want 1", irq); end
    apb_read(3'd0, d, e);
    n_cmp++; if (d !== 8'h03) begin n_bad++; $display("FAIL ovf_status: got %h want 03", d); end
    apb_write(3'd1, 8'h04, e);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL ovf_w1c_irq: got %b want 0", irq); end
    apb_read(3'd5, d, e);
    n_cmp++; if (d !== 8'd4) begin n_bad++; $display("FAIL ovf_lvl: got %0d want 4", d); end
  endtask

  task automatic test_capture_pop_full();
    logic [7:0] d; logic e;
    @(posedge tb_clk); #1;
    rx_data = 8'h5A; data_ready = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd6;
    @(posedge tb_clk); #1;
    penable = 1'b1;
    @(negedge tb_clk);
    n_cmp++; if (prdata !== 8'h10 || data_read !== 1'b1) begin n_bad++; $display("FAIL sim_pop: got %h dr=%b want 10 dr=1", prdata, data_read); end
    @(posedge tb_clk); #1;
    psel = 1'b0; penable = 1'b0; data_ready = 1'b0;
    apb_read(3'd5, d, e);
    n_cmp++; if (d !== 8'd4) begin n_bad++; $display("FAIL sim_lvl: got %0d want 4", d); end
    apb_read(3'd1, d, e);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL sim_no_ovf: got %h want 00", d); end
    apb_read(3'd6, d, e);
    n_cmp++; if (d !== 8'h11) begin n_bad++; $display("FAIL drain_0: got %h want 11", d); end
    apb_read(3'd6, d, e);
    n_cmp++; if (d !== 8'h12) begin n_bad++; $display("FAIL drain_1: got %h want 12", d); end
    apb_read(3'd6, d, e);
    n_cmp++; if (d !== 8'h13) begin n_bad++; $display("FAIL drain_2: got %h want 13", d); end
    apb_read(3'd6, d, e);
    n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL drain_3: got %h want 5a", d); end
  endtask

  task automatic test_threshold();
    logic [7:0] d; logic e; int p; logic [2:0] tr;
    apb_write(3'd7, 8'h82, e);
    deliver(8'h61, 1'b0, 1'b0, p, tr);
    n_cmp++; if (tr !== 3'b000 || irq !== 1'b0) begin n_bad++; $display("FAIL thr_one: got trace=%b irq=%b want 000/0", tr, irq); end
    deliver(8'h62, 1'b0, 1'b0, p, tr);
    n_cmp++; if (tr !== 3'b100) begin n_bad++; $display("FAIL thr_two_timing: got trace=%b want 100", tr); end
    apb_read(3'd6, d, e);
    n_cmp++; if (d !== 8'h61 || irq !== 1'b0) begin n_bad++; $display("FAIL thr_pop: got %h irq=%b want 61 irq=0", d, irq); end
    apb_read(3'd6, d, e);
    apb_write(3'd7, 8'h01, e);
  endtask

  task automatic test_errors();
    logic [7:0] d; logic e; int p; logic [2:0] tr;
    deliver(8'h00, 1'b1, 1'b0, p, tr);
    apb_read(3'd1, d, e);
    n_cmp++; if (d !== 8'h01 || irq !== 1'b1) begin n_bad++; $display("FAIL fe_set: got %h irq=%b want 01 irq=1", d, irq); end
    @(posedge tb_clk); #1;
    data_ready = 1'b1; framing_error = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 8'h01;
    @(posedge tb_clk); #1;
    penable = 1'b1;
    @(posedge tb_clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; data_ready = 1'b0; framing_error = 1'b0;
    apb_read(3'd1, d, e);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL set_wins: got %h want 01", d); end
    apb_write(3'd1, 8'h01, e);
    apb_read(3'd1, d, e);
    n_cmp++; if (d !== 8'h00 || irq !== 1'b0) begin n_bad++; $display("FAIL w1c_clear: got %h irq=%b want 00 irq=0", d, irq); end
    deliver(8'h00, 1'b0, 1'b1, p, tr);
    apb_read(3'd1, d, e);
    n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL oe_set: got %h want 02", d); end
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] d; logic e;
    apb_write(3'd4, 8'h06, e);
    apb_write(3'd7, 8'h85, e);
    @(posedge tb_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd2; pwdata = 8'h55;
    @(posedge tb_clk); #1;
    penable = 1'b1; rst = 1'b1;
    @(posedge tb_clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
    n_cmp++; if (bit_period !== 14'd10 || data_size !== 4'd8) begin n_bad++; $display("FAIL mid_rst_cfg: got bp=%0d ds=%0d want 10/8", bit_period, data_size); end
    n_cmp++; if (irq !== 1'b0 || data_read !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out: got irq=%b dr=%b want 0/0", irq, data_read); end
    apb_read(3'd5, d, e);
    n_cmp++; if (d !== 8'd0) begin n_bad++; $display("FAIL mid_rst_lvl: got %0d want 0", d); end
    apb_read(3'd1, d, e);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL mid_rst_err: got %h want 00", d); end
    apb_read(3'd7, d, e);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL mid_rst_irqcr: got %h want 01", d); end
    apb_read(3'd2, d, e);
    n_cmp++; if (d !== 8'h0A) begin n_bad++; $display("FAIL mid_rst_cr0: got %h want 0a", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bit_period();
    test_capture_read();
    test_overflow();
    test_capture_pop_full();
    test_threshold();
    test_errors();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
